// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared pixel type, frame states and default latch gap
package ws2812b_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_e;

  // 300 us line-low gap at 48 MHz
  localparam int DEFAULT_LATCH_CYCLES = 14400;

endpackage

// File: rtl/ws2812b_pixel_buf.sv
// rtl/ws2812b_pixel_buf.sv - two-bank pixel RAM, write to shadow, registered read from front
module ws2812b_pixel_buf
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_swap,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  pixel_t            i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output pixel_t            o_rd_data
);

  localparam int MEM_W = (2 * NUM_PIXELS > 1) ? $clog2(2 * NUM_PIXELS) : 1;

  pixel_t           r_mem [0:2*NUM_PIXELS-1];
  pixel_t           r_rd_data;
  logic             r_front;
  logic             w_we;
  logic [MEM_W-1:0] w_waddr;
  logic [MEM_W-1:0] w_raddr;

  // Both banks share one array so it maps onto a single block RAM
  assign w_we    = i_wr_en && (32'(i_wr_addr) < NUM_PIXELS);
  assign w_waddr = MEM_W'(i_wr_addr) + (r_front ? MEM_W'(0) : MEM_W'(NUM_PIXELS));
  assign w_raddr = MEM_W'(i_rd_addr) + (r_front ? MEM_W'(NUM_PIXELS) : MEM_W'(0));

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[w_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_front <= 1'b0;
    else if (i_swap) r_front <= ~r_front;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// rtl/ws2812b_frame_ctrl.sv - frame scheduler streaming the front pixel bank to the WS2812B encoder
module ws2812b_frame_ctrl
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS     = 8,
  parameter int ADDR_W         = 3,
  parameter int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  output logic [23:0]       px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_LATCH = LATCH;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_pending;
  logic              r_armed;
  logic [31:0]       r_latch_cnt;
  logic [31:0]       r_timer;
  logic [15:0]       r_frame_count;
  pixel_t            w_rd_data;
  logic              w_swap;
  logic              w_last;
  logic              w_latch_end;
  logic              w_refresh;

  assign w_swap      = (r_state == ST_IDLE) && r_pending;
  assign w_last      = (32'(r_idx) == NUM_PIXELS - 1);
  assign w_latch_end = (r_state == ST_LATCH) && (r_latch_cnt == LATCH_CYCLES - 1);
  // r_armed keeps refresh silent until the first committed frame has been shown
  assign w_refresh   = (REFRESH_CYCLES != 0) && r_armed && (r_timer >= REFRESH_CYCLES);

  ws2812b_pixel_buf #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_swap    (w_swap),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (r_state == ST_LOAD),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_armed       <= 1'b0;
      r_latch_cnt   <= '0;
      r_timer       <= '0;
      r_frame_count <= '0;
    end else begin
      r_pending <= commit | (r_pending & ~w_swap);
      case (r_state)
        ST_IDLE: begin
          if (r_pending || w_refresh) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end else if (r_armed && (REFRESH_CYCLES != 0)) begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_LOAD: r_state <= ST_SEND;
        ST_SEND: begin
          if (px_ready) begin
            if (w_last) begin
              r_state     <= ST_LATCH;
              r_latch_cnt <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LATCH: begin
          if (w_latch_end) begin
            r_state       <= ST_IDLE;
            r_frame_count <= r_frame_count + 16'd1;
            r_timer       <= '0;
            r_armed       <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign px_valid    = (r_state == ST_SEND);
  assign px_data     = px_valid ? w_rd_data : 24'h0;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = w_latch_end;
  assign frame_count = r_frame_count;

endmodule
